param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data and register width in bits; legal 4..32.
REQ-002 SHALL have parameter NREGS, default 16: register count; power of two, 4..64; AW = clog2(NREGS).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): instruction offer/accept; transfer when both are high at a clock edge.
REQ-006 SHALL have ports load_sel (input, 1; 1 = write load_data, 0 = write ALU result) and load_data (input, WIDTH).
REQ-007 SHALL have ports dst_sel, a_sel and b_sel (input, AW each): destination and operand register indices.
REQ-008 SHALL have port op_sel, input, 4: ALU operation.
REQ-009 SHALL have ports wb_valid (output, 1), wb_dst (output, AW) and wb_data (output, WIDTH): write-back stage contents.
REQ-010 SHALL have ports flag_zero and flag_carry, output, 1 each: sticky status flags.
REQ-011 SHALL have ports dbg_sel (input, AW) and dbg_data (output, WIDTH): combinational read-only register view.

Function
REQ-012 SHALL decode op_sel as follows; all other codes SHALL yield zero:
- 0000 ZERO
- 0001 PASS A
- 0010 A-B
- 0100 A+B
- 0101 -A (two's complement)
- 0110 A&B
- 0111 A|B
- 1000 A==B
- 1001 A>B (unsigned)
REQ-013 SHALL truncate arithmetic to WIDTH bits; carry = bit WIDTH of A+B; for A-B, carry = no-borrow (A>=B).
REQ-014 SHALL return compare results as 1 or 0, zero-extended to WIDTH.
REQ-015 SHALL use two stages: EX (operand read plus ALU, registered on accept) and WB (register write).
REQ-016 For an instruction accepted at edge N, SHALL present wb_valid=1, wb_dst and wb_data during cycle N+1; the register file SHALL update at edge N+1.
REQ-017 SHALL hold wb_valid=0 in any cycle that follows an edge with no transfer.
REQ-018 SHALL update flag_zero on every ALU-sourced write-back (1 if result is zero).
REQ-019 SHALL update flag_carry only on ADD and SUB write-backs.
REQ-020 Load-sourced write-backs (load_sel=1) SHALL leave both flags unchanged.
REQ-021 SHALL make dbg_data reflect a completed write in the cycle after the write edge.
REQ-022 SHALL define a RAW hazard as: wb_valid=1 and wb_dst equals a_sel or b_sel of the offered instruction; hazard handling is set by REQ-028/REQ-029.
REQ-023 SHALL keep in_ready independent of in_valid; no combinational path from in_valid to in_ready.
REQ-024 SHALL never drop or duplicate an accepted instruction.

Reset
REQ-025 While rst=1, SHALL drive in_ready=0, wb_valid=0, wb_dst=0, wb_data=0, flag_zero=0, flag_carry=0, and clear all registers to 0.
REQ-026 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL discard any instruction in WB when rst asserts mid-operation; its register write SHALL NOT occur.

Configuration
REQ-028 With DP_FORWARD_EN defined, SHALL bypass wb_data to the matching operand(s) on a RAW hazard, with no stall; in_ready stays 1.
REQ-029 Without DP_FORWARD_EN, SHALL drive in_ready=0 for exactly one cycle on a RAW hazard, then accept the instruction with the register file already updated.

Structure
REQ-030 SHALL place the op_sel encoding constants and the flag bit positions in shared package dp_pkg.
REQ-031 SHALL use sub-module dp_regfile (NREGS x WIDTH, one write port, two read ports plus debug port, async-reset clear); the ALU and pipeline control remain in param_datapath.

Verification
REQ-032 SHALL cover loads: load 2 to r0, 4 to r1, 8 to r2, 16 to r3 on consecutive cycles -> dbg_data 2/4/8/16; flags stay 0.
REQ-033 SHALL cover back-to-back RAW: ADD r15=r0+r1, then ADD r14=r15+r1 -> r15=6, r14=10; forward build 2 consecutive accepts, non-forward build exactly one in_ready=0 cycle.
REQ-034 SHALL cover wrap and carry at WIDTH=8: r4=200, r5=100, ADD -> 44 with flag_carry=1; SUB r4-r5 -> 100 with carry=1; SUB r5-r4 -> 156 with carry=0.
REQ-035 SHALL cover compare and zero: GT(4,8) -> 0 with flag_zero=1; EQ(8,8) -> 1 with flag_zero=0; a following load -> flags unchanged.
REQ-036 SHALL cover mid-operation reset: assert rst in the cycle wb_valid=1 for a write to r9=55 -> r9 reads 0, all outputs at reset values, in_ready=1 one cycle after release.
REQ-037 SHALL cover parameters: WIDTH=16, NREGS=32 -> NEG(1) in r31 = 0xFFFF; out-of-range op code 0011 -> 0.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared op_sel encodings and status flag bit positions for param_datapath.
package dp_pkg;

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_PASS = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_NEG  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_GT   = 4'b1001;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int NFLAGS     = 2;

  // Only the adder/subtractor produce a meaningful carry.
  function automatic logic updatesCarry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// NREGS x WIDTH register file: one write port, two async read ports plus a debug read port.
// Write lands at the clock edge; reads are combinational. Async reset clears every entry.
module dp_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddrA,
  output logic [WIDTH-1:0] rdDataA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] rdDataB,
  input  logic [AW-1:0]    dbgAddr,
  output logic [WIDTH-1:0] dbgData
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdDataA = mem[rdAddrA];
  assign rdDataB = mem[rdAddrB];
  assign dbgData = mem[dbgAddr];

endmodule

// File: rtl/param_datapath.sv
// Two-stage (EX -> WB) register/ALU datapath; result visible in WB one cycle after accept.
// RAW on the WB entry stalls in_ready for one cycle unless DP_FORWARD_EN bypasses wb_data.
module param_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    dst_sel,
  input  logic [AW-1:0]    a_sel,
  input  logic [AW-1:0]    b_sel,
  input  logic [3:0]       op_sel,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_dst,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_zero,
  output logic             flag_carry,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] data;
    logic             updZero;
    logic             updCarry;
    logic             carry;
  } wbStage_t;

  wbStage_t         wbQ;
  logic [NFLAGS-1:0] flagsQ;
  logic [WIDTH-1:0] rfA, rfB, opA, opB;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH:0]   sum;
  logic             aluCarry;
  logic             hazardA, hazardB, accept;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (wbQ.valid),
    .wrAddr  (wbQ.dst),
    .wrData  (wbQ.data),
    .rdAddrA (a_sel),
    .rdDataA (rfA),
    .rdAddrB (b_sel),
    .rdDataB (rfB),
    .dbgAddr (dbg_sel),
    .dbgData (dbg_data)
  );

  assign hazardA = wbQ.valid && (wbQ.dst == a_sel);
  assign hazardB = wbQ.valid && (wbQ.dst == b_sel);

`ifdef DP_FORWARD_EN
  assign opA      = hazardA ? wbQ.data : rfA;
  assign opB      = hazardB ? wbQ.data : rfB;
  assign in_ready = !rst;
`else
  // One bubble lets the pending write land before the operands are read.
  assign opA      = rfA;
  assign opB      = rfB;
  assign in_ready = !rst && !(hazardA || hazardB);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    sum      = {1'b0, opA} + {1'b0, opB};
    case (op_sel)
      OP_ZERO: aluRes = '0;
      OP_PASS: aluRes = opA;
      OP_SUB: begin
        aluRes   = opA - opB;
        aluCarry = (opA >= opB);
      end
      OP_ADD: begin
        aluRes   = sum[WIDTH-1:0];
        aluCarry = sum[WIDTH];
      end
      OP_NEG:  aluRes = -opA;
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_EQ:   aluRes[0] = (opA == opB);
      OP_GT:   aluRes[0] = (opA > opB);
      default: aluRes = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbQ <= '0;
    end else begin
      wbQ.valid <= accept;
      if (accept) begin
        wbQ.dst      <= dst_sel;
        wbQ.data     <= load_sel ? load_data : aluRes;
        wbQ.updZero  <= !load_sel;
        wbQ.updCarry <= !load_sel && updatesCarry(op_sel);
        wbQ.carry    <= aluCarry;
      end
    end
  end

  // Flags follow the write-back, so they change at the same edge as the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagsQ <= '0;
    end else if (wbQ.valid) begin
      if (wbQ.updZero)  flagsQ[FLAG_ZERO]  <= (wbQ.data == '0);
      if (wbQ.updCarry) flagsQ[FLAG_CARRY] <= wbQ.carry;
    end
  end

  assign wb_valid   = wbQ.valid;
  assign wb_dst     = wbQ.dst;
  assign wb_data    = wbQ.data;
  assign flag_zero  = flagsQ[FLAG_ZERO];
  assign flag_carry = flagsQ[FLAG_CARRY];

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath: default 8x16 instance plus a 16-bit x 32 instance.
module tb_param_datapath;
  import dp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, 16-register instance
  logic       inValid8 = 1'b0, loadSel8 = 1'b0;
  logic [7:0] loadData8 = '0;
  logic [3:0] dstSel8 = '0, aSel8 = '0, bSel8 = '0, opSel8 = '0, dbgSel8 = '0;
  logic       inReady8, wbValid8, flagZero8, flagCarry8;
  logic [3:0] wbDst8;
  logic [7:0] wbData8, dbgData8;

  // 16-bit, 32-register instance
  logic        inValid16 = 1'b0, loadSel16 = 1'b0;
  logic [15:0] loadData16 = '0;
  logic [4:0]  dstSel16 = '0, aSel16 = '0, bSel16 = '0, dbgSel16 = '0;
  logic [3:0]  opSel16 = '0;
  logic        inReady16, wbValid16, flagZero16, flagCarry16;
  logic [4:0]  wbDst16;
  logic [15:0] wbData16, dbgData16;

  param_datapath dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
    .load_sel(loadSel8), .load_data(loadData8), .dst_sel(dstSel8),
    .a_sel(aSel8), .b_sel(bSel8), .op_sel(opSel8), .wb_valid(wbValid8),
    .wb_dst(wbDst8), .wb_data(wbData8), .flag_zero(flagZero8),
    .flag_carry(flagCarry8), .dbg_sel(dbgSel8), .dbg_data(dbgData8)
  );

  param_datapath #(.WIDTH(16), .NREGS(32)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
    .load_sel(loadSel16), .load_data(loadData16), .dst_sel(dstSel16),
    .a_sel(aSel16), .b_sel(bSel16), .op_sel(opSel16), .wb_valid(wbValid16),
    .wb_dst(wbDst16), .wb_data(wbData16), .flag_zero(flagZero16),
    .flag_carry(flagCarry16), .dbg_sel(dbgSel16), .dbg_data(dbgData16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Offer one instruction; returns #1 after the accepting edge (WB now holds it).
  task automatic send8(input logic ld, input logic [7:0] d, input logic [3:0] dst,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output int stalls);
    loadSel8 = ld; loadData8 = d; dstSel8 = dst; aSel8 = a; bSel8 = b; opSel8 = op;
    inValid8 = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (inReady8 !== 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    chk("accept_timeout8", 32'(stalls < 8), 32'd1);
    @(posedge clk); #1;
    inValid8 = 1'b0;
  endtask

  task automatic send16(input logic ld, input logic [15:0] d, input logic [4:0] dst,
                        input logic [4:0] a, input logic [4:0] b, input logic [3:0] op);
    int stalls;
    loadSel16 = ld; loadData16 = d; dstSel16 = dst; aSel16 = a; bSel16 = b; opSel16 = op;
    inValid16 = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (inReady16 !== 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    chk("accept_timeout16", 32'(stalls < 8), 32'd1);
    @(posedge clk); #1;
    inValid16 = 1'b0;
  endtask

  logic [3:0] tblOp  [8] = '{OP_PASS, OP_AND, OP_OR, OP_NEG, OP_ZERO, 4'b0011, OP_EQ, OP_GT};
  logic [7:0] tblExp [8] = '{8'd200, 8'd64, 8'd236, 8'd56, 8'd0, 8'd0, 8'd0, 8'd1};
  logic [7:0] loadVals [4] = '{8'd2, 8'd4, 8'd8, 8'd16};

  initial begin
    int st, total;

    // Reset state
    #2;
    chk("rst_in_ready", inReady8, 0);
    chk("rst_wb_valid", wbValid8, 0);
    chk("rst_wb_dst", wbDst8, 0);
    chk("rst_wb_data", wbData8, 0);
    chk("rst_flag_zero", flagZero8, 0);
    chk("rst_flag_carry", flagCarry8, 0);
    chk("rst_in_ready16", inReady16, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", inReady8, 1);

    // Consecutive loads r0..r3
    total = 0;
    for (int i = 0; i < 4; i++) begin
      send8(1'b1, loadVals[i], 4'(i), 4'(i), 4'(i), OP_ZERO, st);
      total += st;
      chk("load_wb_valid", wbValid8, 1);
      chk("load_wb_data", wbData8, 32'(loadVals[i]));
    end
    chk("load_no_stall", total, 0);
    idle();
    chk("idle_wb_valid", wbValid8, 0);
    for (int i = 0; i < 4; i++) begin
      dbgSel8 = 4'(i); #1;
      chk("load_dbg", dbgData8, 32'(loadVals[i]));
    end
    chk("load_flag_zero", flagZero8, 0);
    chk("load_flag_carry", flagCarry8, 0);

    // Back-to-back RAW
    send8(1'b0, 8'd0, 4'd15, 4'd0, 4'd1, OP_ADD, st);
    chk("raw1_dst", wbDst8, 15);
    chk("raw1_data", wbData8, 6);
    send8(1'b0, 8'd0, 4'd14, 4'd15, 4'd1, OP_ADD, st);
`ifdef DP_FORWARD_EN
    chk("raw_stalls", st, 0);
`else
    chk("raw_stalls", st, 1);
`endif
    chk("raw2_dst", wbDst8, 14);
    chk("raw2_data", wbData8, 10);
    idle();
    dbgSel8 = 4'd15; #1; chk("dbg_r15", dbgData8, 6);
    dbgSel8 = 4'd14; #1; chk("dbg_r14", dbgData8, 10);

    // Wrap and carry
    send8(1'b1, 8'd200, 4'd4, 4'd4, 4'd4, OP_ZERO, st);
    send8(1'b1, 8'd100, 4'd5, 4'd5, 4'd5, OP_ZERO, st);
    send8(1'b0, 8'd0, 4'd6, 4'd4, 4'd5, OP_ADD, st);
    chk("add_wrap", wbData8, 44);
    idle();
    chk("add_carry", flagCarry8, 1);
    chk("add_zero", flagZero8, 0);
    send8(1'b0, 8'd0, 4'd8, 4'd5, 4'd4, OP_SUB, st);
    chk("sub_borrow", wbData8, 156);
    idle();
    chk("sub_borrow_carry", flagCarry8, 0);
    send8(1'b0, 8'd0, 4'd7, 4'd4, 4'd5, OP_SUB, st);
    chk("sub_noborrow", wbData8, 100);
    idle();
    chk("sub_noborrow_carry", flagCarry8, 1);

    // Compare and zero; carry must survive non-arith ops and loads
    send8(1'b0, 8'd0, 4'd10, 4'd1, 4'd2, OP_GT, st);
    chk("gt_data", wbData8, 0);
    idle();
    chk("gt_zero", flagZero8, 1);
    chk("gt_carry_kept", flagCarry8, 1);
    send8(1'b0, 8'd0, 4'd11, 4'd2, 4'd2, OP_EQ, st);
    chk("eq_data", wbData8, 1);
    idle();
    chk("eq_zero", flagZero8, 0);
    send8(1'b1, 8'd0, 4'd12, 4'd12, 4'd12, OP_ZERO, st);
    idle();
    chk("load_keeps_zero", flagZero8, 0);
    chk("load_keeps_carry", flagCarry8, 1);

    // Remaining op codes on r4=200, r5=100
    for (int i = 0; i < 8; i++) begin
      send8(1'b0, 8'd0, 4'd13, 4'd4, 4'd5, tblOp[i], st);
      chk($sformatf("op_%b", tblOp[i]), wbData8, 32'(tblExp[i]));
    end

    // Mid-operation reset while r9=55 sits in WB
    send8(1'b1, 8'd55, 4'd9, 4'd9, 4'd9, OP_ZERO, st);
    chk("pre_rst_wb_valid", wbValid8, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wb_valid", wbValid8, 0);
    chk("mid_rst_wb_dst", wbDst8, 0);
    chk("mid_rst_wb_data", wbData8, 0);
    chk("mid_rst_in_ready", inReady8, 0);
    chk("mid_rst_flag_zero", flagZero8, 0);
    chk("mid_rst_flag_carry", flagCarry8, 0);
    idle(); idle();
    rst = 1'b0;
    idle();
    chk("post_rst_ready", inReady8, 1);
    chk("post_rst_wb_valid", wbValid8, 0);
    dbgSel8 = 4'd9; #1; chk("post_rst_r9", dbgData8, 0);
    dbgSel8 = 4'd4; #1; chk("post_rst_r4", dbgData8, 0);

    // Wider instance
    send16(1'b1, 16'd1, 5'd0, 5'd0, 5'd0, OP_ZERO);
    send16(1'b0, 16'd0, 5'd31, 5'd0, 5'd0, OP_NEG);
    chk("w16_neg_dst", wbDst16, 31);
    chk("w16_neg_data", wbData16, 32'hFFFF);
    send16(1'b0, 16'd0, 5'd30, 5'd31, 5'd31, 4'b0011);
    chk("w16_badop", wbData16, 0);
    send16(1'b0, 16'd0, 5'd29, 5'd31, 5'd0, OP_ADD);
    chk("w16_add_wrap", wbData16, 0);
    idle();
    chk("w16_carry", flagCarry16, 1);
    chk("w16_zero", flagZero16, 1);
    dbgSel16 = 5'd31; #1;
    chk("w16_dbg_r31", dbgData16, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
